// File: rtl/mem_pkg.sv
// Shared types and constants for the lc_* line interface.
package mem_pkg;

    localparam int unsigned LC_LINE_BITS   = 512;
    localparam int unsigned LC_OFFSET_BITS = 6;

    // One queued line request as captured at the request handshake.
    typedef struct packed {
        logic [63:0]             addr;
        logic [LC_LINE_BITS-1:0] value;
        logic                    we;
    } lc_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lc_resp_state_e;

endpackage

// File: rtl/lc_req_fifo.sv
// Synchronous FIFO of lc_req_t with full/empty flags. The caller must not
// push when full or pop when empty.
module lc_req_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  lc_req_t wdata,
    output lc_req_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    lc_req_t          entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Flags come from the registered count only.
    always_comb begin
        rdata = entries[rd_ptr];
        full  = (count == (PTR_W + 1)'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/llc_responder.sv
// LLC-side responder: queues line requests, applies writes immediately and
// returns reads after a fixed latency under a valid/ready handshake.
module llc_responder
    import mem_pkg::*;
#(
    parameter int unsigned LINES       = 1024,
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned REQ_DEPTH   = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_N_in,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic [63:0]             req_addr_in,
    input  logic [LC_LINE_BITS-1:0] req_value_in,
    input  logic                    req_we_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic [63:0]             resp_addr_out,
    output logic [LC_LINE_BITS-1:0] resp_value_out
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    lc_resp_state_e          state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        rd_idx;
    logic [63:0]             rd_addr;
    logic [LC_LINE_BITS-1:0] mem [LINES];

    lc_req_t  push_req;
    lc_req_t  head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;
    logic [IDX_W-1:0] head_idx;

    // Handshake and pop decode; the FIFO head is consumed only from IDLE.
    always_comb begin
        req_ready_out  = !fifo_full;
        push           = req_valid_in && !fifo_full;
        pop            = (state == IDLE) && !fifo_empty;
        push_req.addr  = req_addr_in;
        push_req.value = req_value_in;
        push_req.we    = req_we_in;
        // Upper address bits alias silently onto the line index.
        head_idx       = head.addr[LC_OFFSET_BITS +: IDX_W];
    end

    lc_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk_in),
        .rst_n (rst_N_in),
        .push  (push),
        .pop   (pop),
        .wdata (push_req),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Backing storage: written when a write pops, never reset.
    always_ff @(posedge clk_in) begin
        if (pop && head.we) begin
            mem[head_idx] <= head.value;
        end
    end

    // Read FSM, latency counter and response registers.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state          <= IDLE;
            cnt            <= '0;
            rd_idx         <= '0;
            rd_addr        <= '0;
            resp_valid_out <= 1'b0;
            resp_addr_out  <= '0;
            resp_value_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop && !head.we) begin
                        rd_idx  <= head_idx;
                        rd_addr <= head.addr & ~64'(2 ** LC_OFFSET_BITS - 1);
                        cnt     <= CNT_W'(MEM_LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_value_out <= mem[rd_idx];
                        resp_addr_out  <= rd_addr;
                        resp_valid_out <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        resp_valid_out <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_responder.sv
// Self-checking bench for llc_responder: a reference line memory and an
// in-order scoreboard of expected read responses.
module tb_llc_responder;

    logic         clk_in = 1'b0;
    logic         rst_N_in;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [63:0]  req_addr_in;
    logic [511:0] req_value_in;
    logic         req_we_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [63:0]  resp_addr_out;
    logic [511:0] resp_value_out;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] value;
    } exp_t;

    exp_t         sb [$];
    logic [511:0] model_mem [int];
    int           n_checks = 0;
    int           n_pass   = 0;

    // Backpressure stability tracking for the monitor.
    logic         held = 1'b0;
    logic [63:0]  held_addr;
    logic [511:0] held_value;

    llc_responder dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_addr_in    (req_addr_in),
        .req_value_in   (req_value_in),
        .req_we_in      (req_we_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_addr_out  (resp_addr_out),
        .resp_value_out (resp_value_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Response monitor: pops the scoreboard on each response handshake and
    // checks that a stalled response holds still.
    always @(negedge clk_in) begin
        if (!rst_N_in) begin
            held = 1'b0;
        end else begin
            if (held) begin
                n_checks++;
                if (resp_valid_out !== 1'b1 || resp_addr_out !== held_addr ||
                    resp_value_out !== held_value) begin
                    $display("FAIL stall_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                             resp_valid_out, resp_addr_out, held_addr);
                end else begin
                    n_pass++;
                end
            end
            held       = resp_valid_out && !resp_ready_in;
            held_addr  = resp_addr_out;
            held_value = resp_value_out;
            if (resp_valid_out && resp_ready_in) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_resp: got addr=%h, required no response",
                             resp_addr_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (resp_addr_out !== e.addr || resp_value_out !== e.value) begin
                        $display("FAIL resp_data: got addr=%h value=%h, required addr=%h value=%h",
                                 resp_addr_out, resp_value_out, e.addr, e.value);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    function automatic int line_of(input logic [63:0] a);
        return int'(a[15:6]);
    endfunction

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic push_req(input logic [63:0] a, input logic [511:0] v, input logic we);
        bit ok;
        exp_t e;
        req_valid_in = 1'b1;
        req_addr_in  = a;
        req_value_in = v;
        req_we_in    = we;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_in);
            ok = req_ready_out;
            @(posedge clk_in);
            #1;
        end
        req_valid_in = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL req_accept: got ready=0 for 200 cycles, required acceptance");
        end else if (we) begin
            model_mem[line_of(a)] = v;
        end else begin
            e.addr  = {a[63:6], 6'b0};
            e.value = model_mem[line_of(a)];
            sb.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clk_in);
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL %s_drain: got %0d pending, required 0", name, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_N_in      = 1'b0;
        req_valid_in  = 1'b0;
        req_addr_in   = '0;
        req_value_in  = '0;
        req_we_in     = 1'b0;
        resp_ready_in = 1'b1;
        #12;
        n_checks++;
        if (req_ready_out !== 1'b1 || resp_valid_out !== 1'b0 ||
            resp_addr_out !== 64'h0 || resp_value_out !== 512'h0) begin
            $display("FAIL reset_values: got ready=%b valid=%b addr=%h, required 1 0 0",
                     req_ready_out, resp_valid_out, resp_addr_out);
        end else begin
            n_pass++;
        end
        @(posedge clk_in);
        #1;
        rst_N_in = 1'b1;
        idle_cycles(10);
        n_checks++;
        if (req_ready_out !== 1'b1 || resp_valid_out !== 1'b0) begin
            $display("FAIL idle_quiet: got ready=%b valid=%b, required 1 0",
                     req_ready_out, resp_valid_out);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_write_read;
        int first;
        push_req(64'h1040, {64{8'hA5}}, 1'b1);
        idle_cycles(3);
        push_req(64'h107F, '0, 1'b0);
        // Now in cycle T+1 relative to the read handshake.
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            @(negedge clk_in);
            if (resp_valid_out) first = i;
        end
        n_checks++;
        if (first != 6) begin
            $display("FAIL read_latency: got %0d cycles, required 6", first);
        end else begin
            n_pass++;
        end
        n_checks++;
        if (resp_addr_out !== 64'h1040 || resp_value_out !== {64{8'hA5}}) begin
            $display("FAIL wr_rd_direct: got addr=%h, required addr=%h",
                     resp_addr_out, 64'h1040);
        end else begin
            n_pass++;
        end
        @(posedge clk_in);
        #1;
        wait_drain("write_read");
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 5; k++) begin
            push_req(64'h4000 + 64'(k * 64), {16{32'(k) * 32'h01010101 ^ 32'hDEADBEEF}}, 1'b1);
        end
        idle_cycles(2);
        resp_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_req(64'h4000 + 64'(k * 64) + 64'(k), '0, 1'b0);
        end
        @(negedge clk_in);
        n_checks++;
        if (req_ready_out !== 1'b0) begin
            $display("FAIL fifo_full: got ready=%b, required 0", req_ready_out);
        end else begin
            n_pass++;
        end
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 20 && !resp_valid_out; i++) idle_cycles(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            n_checks++;
            if (resp_valid_out !== 1'b1 || req_ready_out !== 1'b0) begin
                $display("FAIL bp_hold: got valid=%b ready=%b, required 1 0",
                         resp_valid_out, req_ready_out);
            end else begin
                n_pass++;
            end
        end
        @(posedge clk_in);
        #1;
        resp_ready_in = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back;
        push_req(64'h2000, {16{32'h1111_2222}}, 1'b1);
        push_req(64'h2000, '0, 1'b0);
        push_req(64'h2000, {16{32'h3333_4444}}, 1'b1);
        push_req(64'h2000, '0, 1'b0);
        wait_drain("raw_order");
    endtask

    task automatic test_alias;
        push_req(64'h0, {8{64'h0123_4567_89AB_CDEF}}, 1'b1);
        push_req(64'h10000, '0, 1'b0);
        wait_drain("alias");
    endtask

    task automatic test_reset_midop;
        exp_t e;
        push_req(64'h8000, {16{32'hCAFE_F00D}}, 1'b1);
        push_req(64'h8040, {16{32'h5A5A_0F0F}}, 1'b1);
        idle_cycles(2);
        push_req(64'h8000, '0, 1'b0);
        push_req(64'h8040, '0, 1'b0);
        push_req(64'h8000, '0, 1'b0);
        rst_N_in = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
            $display("FAIL midop_reset: got valid=%b ready=%b, required 0 1",
                     resp_valid_out, req_ready_out);
        end else begin
            n_pass++;
        end
        idle_cycles(2);
        rst_N_in = 1'b1;
        idle_cycles(20);
        n_checks++;
        if (resp_valid_out !== 1'b0) begin
            $display("FAIL stale_resp: got valid=%b, required 0", resp_valid_out);
        end else begin
            n_pass++;
        end
        push_req(64'h8040, '0, 1'b0);
        e = sb[0];
        n_checks++;
        if (e.value !== {16{32'h5A5A_0F0F}}) begin
            $display("FAIL model_retained: got %h, required %h", e.value, {16{32'h5A5A_0F0F}});
        end else begin
            n_pass++;
        end
        wait_drain("retained");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_alias();
        test_reset_midop();
        idle_cycles(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
